// File: rtl/rv_mem_arb.sv
// Single-port memory arbiter between instruction fetch and load/store.
// One outstanding access at a time; data side wins unless fetch has been starved.
module rv_mem_arb #(
   parameter int unsigned AW         = 32,
   parameter int unsigned DW         = 32,
   parameter int unsigned MEM_LAT    = 1,
   parameter int unsigned STARVE_LIM = 4
) (
   input  logic            clk,
   input  logic            rstn,
   input  logic            if_req_i,
   input  logic [AW-1:0]   if_addr_i,
   output logic            if_gnt_o,
   output logic            if_rvalid_o,
   output logic [DW-1:0]   if_rdata_o,
   input  logic            d_req_i,
   input  logic            d_we_i,
   input  logic [AW-1:0]   d_addr_i,
   input  logic [DW-1:0]   d_wdata_i,
   input  logic [DW/8-1:0] d_be_i,
   output logic            d_gnt_o,
   output logic            d_rvalid_o,
   output logic [DW-1:0]   d_rdata_o,
   output logic            mem_req_o,
   output logic            mem_we_o,
   output logic [AW-1:0]   mem_addr_o,
   output logic [DW-1:0]   mem_wdata_o,
   output logic [DW/8-1:0] mem_be_o,
   input  logic [DW-1:0]   mem_rdata_i
);

   localparam logic S_IDLE = 1'b0;
   localparam logic S_BUSY = 1'b1;
   localparam int unsigned CW = 4;

   logic          r_state;
   logic          r_owner;  // 0 = fetch, 1 = data
   logic          r_we;
   logic [CW-1:0] r_cnt;
   logic [CW-1:0] r_starve_cnt;

   logic w_done;
   logic w_cap;
   logic w_starved;
   logic w_if_win;
   logic w_d_win;
   logic w_if_gnt;
   logic w_d_gnt;
   logic w_gnt;

   always_comb begin
      w_done    = (r_state == S_BUSY) && (r_cnt == CW'(1));
      w_cap     = (r_state == S_IDLE) || w_done;
      w_starved = (r_starve_cnt == CW'(STARVE_LIM));
      w_if_win  = if_req_i && (!d_req_i || w_starved);
      w_d_win   = d_req_i && !w_if_win;
      // Outputs are forced low throughout reset, including the combinational grants.
      w_if_gnt  = rstn && w_cap && w_if_win;
      w_d_gnt   = rstn && w_cap && w_d_win;
      w_gnt     = w_if_gnt || w_d_gnt;
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_state      <= S_IDLE;
         r_owner      <= 1'b0;
         r_we         <= 1'b0;
         r_cnt        <= '0;
         r_starve_cnt <= '0;
      end else begin
         if (w_gnt) begin
            r_state <= S_BUSY;
            r_owner <= w_d_gnt;
            r_we    <= w_d_gnt && d_we_i;
            r_cnt   <= CW'(MEM_LAT);
         end else if (r_state == S_BUSY) begin
            r_cnt <= r_cnt - CW'(1);
            if (w_done) begin
               r_state <= S_IDLE;
            end
         end

         if (w_gnt) begin
            if (w_if_gnt || !if_req_i) begin
               r_starve_cnt <= '0;
            end else if (!w_starved) begin
               r_starve_cnt <= r_starve_cnt + CW'(1);
            end
         end
      end
   end

   always_comb begin
      if_gnt_o    = w_if_gnt;
      d_gnt_o     = w_d_gnt;
      if_rvalid_o = rstn && w_done && !r_owner;
      d_rvalid_o  = rstn && w_done && r_owner;
      if_rdata_o  = if_rvalid_o ? mem_rdata_i : '0;
      d_rdata_o   = (d_rvalid_o && !r_we) ? mem_rdata_i : '0;

      mem_req_o   = w_gnt;
      mem_we_o    = 1'b0;
      mem_addr_o  = '0;
      mem_wdata_o = '0;
      mem_be_o    = '0;
      if (w_d_gnt) begin
         mem_we_o    = d_we_i;
         mem_addr_o  = d_addr_i;
         mem_wdata_o = d_wdata_i;
         mem_be_o    = d_we_i ? d_be_i : '1;
      end else if (w_if_gnt) begin
         mem_addr_o  = if_addr_i;
         mem_be_o    = '1;
      end
   end

endmodule

// File: tb/tb_rv_mem_arb.sv
// Directed bench for rv_mem_arb; three instances share stimulus with MEM_LAT = 1, 3 and 4.
module tb_rv_mem_arb;

   logic        clk;
   logic        rstn;
   logic        if_req;
   logic [31:0] if_addr;
   logic        d_req;
   logic        d_we;
   logic [31:0] d_addr;
   logic [31:0] d_wdata;
   logic [3:0]  d_be;
   logic [31:0] mem_rdata;

   logic        if_gnt[3];
   logic        if_rvalid[3];
   logic [31:0] if_rdata[3];
   logic        d_gnt[3];
   logic        d_rvalid[3];
   logic [31:0] d_rdata[3];
   logic        mem_req[3];
   logic        mem_we[3];
   logic [31:0] mem_addr[3];
   logic [31:0] mem_wdata[3];
   logic [3:0]  mem_be[3];

   int checks = 0;
   int errors = 0;

   for (genvar g = 0; g < 3; g++) begin : g_dut
      rv_mem_arb #(
         .AW(32),
         .DW(32),
         .MEM_LAT((g == 0) ? 1 : (g == 1) ? 3 : 4),
         .STARVE_LIM(4)
      ) u_dut (
         .clk(clk),
         .rstn(rstn),
         .if_req_i(if_req),
         .if_addr_i(if_addr),
         .if_gnt_o(if_gnt[g]),
         .if_rvalid_o(if_rvalid[g]),
         .if_rdata_o(if_rdata[g]),
         .d_req_i(d_req),
         .d_we_i(d_we),
         .d_addr_i(d_addr),
         .d_wdata_i(d_wdata),
         .d_be_i(d_be),
         .d_gnt_o(d_gnt[g]),
         .d_rvalid_o(d_rvalid[g]),
         .d_rdata_o(d_rdata[g]),
         .mem_req_o(mem_req[g]),
         .mem_we_o(mem_we[g]),
         .mem_addr_o(mem_addr[g]),
         .mem_wdata_o(mem_wdata[g]),
         .mem_be_o(mem_be[g]),
         .mem_rdata_i(mem_rdata)
      );
   end

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic any_out(input int g);
      return if_gnt[g] | if_rvalid[g] | (|if_rdata[g]) | d_gnt[g] | d_rvalid[g] |
             (|d_rdata[g]) | mem_req[g] | mem_we[g] | (|mem_addr[g]) | (|mem_wdata[g]) |
             (|mem_be[g]);
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      if_req  = 1'b0;
      if_addr = '0;
      d_req   = 1'b0;
      d_we    = 1'b0;
      d_addr  = '0;
      d_wdata = '0;
      d_be    = '0;
   endtask

   task automatic do_reset();
      rstn = 1'b0;
      idle_inputs();
      repeat (2) @(posedge clk);
      #1;
      rstn = 1'b1;
   endtask

   initial begin
      rstn      = 1'b0;
      mem_rdata = 32'hCAFE_F00D;
      idle_inputs();

      // Reset: requests asserted but every output must stay low
      if_req = 1'b1;
      d_req  = 1'b1;
      if_addr = 32'h10;
      d_addr  = 32'h20;
      #2;
      for (int g = 0; g < 3; g++) chk($sformatf("rst_outs_%0d", g), 64'(any_out(g)), 64'd0);
      do_reset();
      #1;
      for (int g = 0; g < 3; g++) chk($sformatf("idle_outs_%0d", g), 64'(any_out(g)), 64'd0);

      // 1: lone fetch, MEM_LAT=1
      do_reset();
      if_req = 1'b1;
      if_addr = 32'h100;
      mem_rdata = 32'hDEAD_BEEF;
      #1;
      chk("t1_if_gnt", 64'(if_gnt[0]), 64'd1);
      chk("t1_d_gnt", 64'(d_gnt[0]), 64'd0);
      chk("t1_mem_addr", 64'(mem_addr[0]), 64'h100);
      chk("t1_mem_be", 64'(mem_be[0]), 64'hF);
      chk("t1_mem_we", 64'(mem_we[0]), 64'd0);
      step();
      if_req = 1'b0;
      #1;
      chk("t1_if_rvalid", 64'(if_rvalid[0]), 64'd1);
      chk("t1_if_rdata", 64'(if_rdata[0]), 64'hDEAD_BEEF);
      chk("t1_no_gnt", 64'(if_gnt[0]), 64'd0);
      step();
      chk("t1_rvalid_pulse", 64'(if_rvalid[0]), 64'd0);
      chk("t1_rdata_zero", 64'(if_rdata[0]), 64'd0);

      // 2: fetch and load together, MEM_LAT=3
      do_reset();
      if_req = 1'b1;
      if_addr = 32'h300;
      d_req = 1'b1;
      d_addr = 32'h200;
      mem_rdata = 32'hA5A5_0001;
      #1;
      chk("t2_c0_gnt", 64'({if_gnt[1], d_gnt[1]}), 64'b01);
      chk("t2_c0_addr", 64'(mem_addr[1]), 64'h200);
      step();
      d_req = 1'b0;
      #1;
      chk("t2_c1_quiet", 64'({if_gnt[1], d_gnt[1], if_rvalid[1], d_rvalid[1]}), 64'd0);
      step();
      chk("t2_c2_quiet", 64'({if_gnt[1], d_gnt[1], if_rvalid[1], d_rvalid[1]}), 64'd0);
      step();
      chk("t2_c3_d_rvalid", 64'(d_rvalid[1]), 64'd1);
      chk("t2_c3_d_rdata", 64'(d_rdata[1]), 64'hA5A5_0001);
      chk("t2_c3_gnt", 64'({if_gnt[1], d_gnt[1]}), 64'b10);
      chk("t2_c3_addr", 64'(mem_addr[1]), 64'h300);
      step();
      if_req = 1'b0;
      mem_rdata = 32'h1111_2222;
      #1;
      chk("t2_c4_quiet", 64'({if_rvalid[1], d_rvalid[1]}), 64'd0);
      step();
      step();
      chk("t2_c6_if_rvalid", 64'(if_rvalid[1]), 64'd1);
      chk("t2_c6_if_rdata", 64'(if_rdata[1]), 64'h1111_2222);
      chk("t2_c6_d_rvalid", 64'(d_rvalid[1]), 64'd0);

      // 3: continuous contention, STARVE_LIM=4, MEM_LAT=1
      do_reset();
      if_req = 1'b1;
      if_addr = 32'h400;
      d_req = 1'b1;
      d_addr = 32'h404;
      for (int i = 0; i < 10; i++) begin
         #1;
         chk($sformatf("t3_gnt_%0d", i), 64'({if_gnt[0], d_gnt[0]}),
             (i % 5 == 4) ? 64'b10 : 64'b01);
         step();
      end
      idle_inputs();

      // 4: store, MEM_LAT=3
      do_reset();
      d_req = 1'b1;
      d_we = 1'b1;
      d_addr = 32'h40;
      d_wdata = 32'h1234_5678;
      d_be = 4'b0011;
      mem_rdata = 32'hFFFF_FFFF;
      #1;
      chk("t4_gnt", 64'(d_gnt[1]), 64'd1);
      chk("t4_mem", 64'({mem_req[1], mem_we[1], mem_addr[1], mem_wdata[1], mem_be[1]}),
          {2'b11, 32'h40, 32'h1234_5678, 4'b0011});
      step();
      idle_inputs();
      #1;
      chk("t4_c1_rvalid", 64'(d_rvalid[1]), 64'd0);
      step();
      step();
      chk("t4_c3_rvalid", 64'(d_rvalid[1]), 64'd1);
      chk("t4_c3_rdata", 64'(d_rdata[1]), 64'd0);

      // 5: reset mid-transaction, MEM_LAT=4
      do_reset();
      if_req = 1'b1;
      if_addr = 32'h500;
      mem_rdata = 32'h5555_AAAA;
      #1;
      chk("t5_gnt", 64'(if_gnt[2]), 64'd1);
      step();
      if_req = 1'b0;
      step();
      rstn = 1'b0;
      if_req = 1'b1;
      d_req = 1'b1;
      #1;
      chk("t5_rst_outs", 64'(any_out(2)), 64'd0);
      step();
      idle_inputs();
      rstn = 1'b1;
      for (int i = 0; i < 5; i++) begin
         #1;
         chk($sformatf("t5_no_rvalid_%0d", i), 64'({if_rvalid[2], d_rvalid[2]}), 64'd0);
         step();
      end
      if_req = 1'b1;
      if_addr = 32'h504;
      #1;
      chk("t5_regrant", 64'(if_gnt[2]), 64'd1);
      chk("t5_regrant_addr", 64'(mem_addr[2]), 64'h504);
      step();
      if_req = 1'b0;
      step();
      step();
      step();
      chk("t5_rvalid", 64'(if_rvalid[2]), 64'd1);

      // 6: fetch request withdrawn while load is busy, MEM_LAT=3
      do_reset();
      d_req = 1'b1;
      d_addr = 32'h60;
      mem_rdata = 32'h0BAD_F00D;
      #1;
      chk("t6_d_gnt", 64'(d_gnt[1]), 64'd1);
      step();
      d_req = 1'b0;
      if_req = 1'b1;
      if_addr = 32'h600;
      #1;
      chk("t6_c1_no_gnt", 64'({if_gnt[1], mem_req[1]}), 64'd0);
      step();
      if_req = 1'b0;
      #1;
      chk("t6_c2_no_gnt", 64'({if_gnt[1], mem_req[1]}), 64'd0);
      step();
      chk("t6_c3_rvalid", 64'(d_rvalid[1]), 64'd1);
      chk("t6_c3_rdata", 64'(d_rdata[1]), 64'h0BAD_F00D);
      chk("t6_c3_no_gnt", 64'({if_gnt[1], mem_req[1]}), 64'd0);
      step();
      chk("t6_state_idle", 64'(g_dut[1].u_dut.r_state), 64'd0);
      chk("t6_starve_zero", 64'(g_dut[1].u_dut.r_starve_cnt), 64'd0);
      d_req = 1'b1;
      d_addr = 32'h64;
      #1;
      chk("t6_idle_gnt", 64'(d_gnt[1]), 64'd1);
      step();
      idle_inputs();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
